// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU one bit per cycle,
// plus single-cycle MTHI/MTLO, with a start/busy/done handshake.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opnd_b;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] step_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = (state == IDLE) && start && !op[2];
  assign a_neg  = op[0] && a[WIDTH-1];
  assign b_neg  = op[0] && b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign busy   = (state != IDLE);

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    if (!is_div)
      step_nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      step_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      step_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Divide by zero runs on the raw dividend with no sign flags, which leaves
  // quotient all-ones and remainder equal to a without a special FIX path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd_b <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept) begin
            count  <= CW'(WIDTH - 1);
            is_div <= op[1];
            if (op[1] && (b == '0)) begin
              acc    <= {{WIDTH{1'b0}}, a};
              opnd_b <= '0;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
            end else begin
              acc    <= {{WIDTH{1'b0}}, a_mag};
              opnd_b <= b_mag;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
            end
          end else if (start && op == 3'b100) begin
            hi <= a;
          end else if (start && op == 3'b101) begin
            lo <= a;
          end
        end
        RUN: begin
          acc   <= step_nxt;
          count <= count - 1'b1;
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
